vr_consumer: RTL and testbench

Receiving end of the `vr_i` valid/ready channel: accepts 8-bit words from a producer, throttles the channel with a configurable busy interval after each accept, and reports what it received. An optional in-line sequence checker confirms the stream is an incrementing count and flags gaps. It sits opposite the producer on the same `vr_i` instance and is the standard sink for handshake testbenches and bring-up.

---
 rtl/vr_pkg.sv | 18 +
 rtl/vr_if.sv | 12 +
 rtl/vr_seq_check.sv | 37 +++
 rtl/vr_consumer.sv | 96 +++++++++
 tb/tb_vr_consumer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vr_pkg.sv
// rtl/vr_pkg.sv - shared types and constants for the vr_i valid/ready channel
package vr_pkg;

    localparam int VR_DATA_W    = 8;
    localparam int VR_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        C_IDLE,
        C_RDY,
        C_BUSY
    } cn_state_t;

    // Successor in the incrementing test stream; wraps FF -> 00.
    function automatic logic [VR_DATA_W-1:0] vr_next_seq(input logic [VR_DATA_W-1:0] d);
        return d + VR_DATA_W'(1);
    endfunction

endpackage

// File: rtl/vr_if.sv
// rtl/vr_if.sv - vr_i valid/ready channel shared by producer and consumer
interface vr_i;
    import vr_pkg::*;

    logic                 valid;
    logic [VR_DATA_W-1:0] data;
    logic                 rdy;

    modport pr_port (output valid, output data, input  rdy);
    modport cn_port (input  valid, input  data, output rdy);

endinterface

// File: rtl/vr_seq_check.sv
// rtl/vr_seq_check.sv - incrementing-count stream checker, built only with VR_CONSUMER_CHECK_EN
`ifdef VR_CONSUMER_CHECK_EN
module vr_seq_check
    import vr_pkg::*;
#(
    parameter logic [VR_DATA_W-1:0] EXP_INIT = 8'h01,
    parameter int                   CNT_W    = VR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 xfer,
    input  logic [VR_DATA_W-1:0] data,
    output logic                 err,
    output logic [CNT_W-1:0]     err_count
);

    logic [VR_DATA_W-1:0] expected;

    // On a match data+1 equals expected+1, so both cases resync the same way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected  <= EXP_INIT;
            err       <= 1'b0;
            err_count <= '0;
        end else if (xfer) begin
            expected <= vr_next_seq(data);
            if (data != expected) begin
                err <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
`endif

// File: rtl/vr_consumer.sv
// rtl/vr_consumer.sv - vr_i sink with busy throttle and stats; sequence checker under VR_CONSUMER_CHECK_EN
module vr_consumer
    import vr_pkg::*;
#(
    parameter int                   BUSY_CYCLES = 3,
    parameter logic [VR_DATA_W-1:0] EXP_INIT    = 8'h01,
    parameter int                   CNT_W       = VR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    vr_i.cn_port                 crp,
    input  logic                 stall,
    output logic [VR_DATA_W-1:0] rx_data,
    output logic                 rx_stb,
    output logic [CNT_W-1:0]     rx_count,
    output logic                 err,
    output logic [CNT_W-1:0]     err_count
);

    localparam int              BC_W    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [BC_W-1:0] BC_LOAD = BC_W'((BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0);

    cn_state_t       state_q, state_d;
    logic [BC_W-1:0] busy_q, busy_d;
    logic            rdy;
    logic            xfer;

    // rdy never looks at valid, so the producer cannot form a combinational loop through us.
    assign rdy     = (state_q == C_RDY) & ~stall;
    assign crp.rdy = rdy;
    assign xfer    = crp.valid & rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= C_IDLE;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        unique case (state_q)
            C_IDLE: state_d = C_RDY;
            C_RDY: begin
                if (xfer && (BUSY_CYCLES != 0)) begin
                    state_d = C_BUSY;
                    busy_d  = BC_LOAD;
                end
            end
            C_BUSY: begin
                if (busy_q == '0) begin
                    state_d = C_RDY;
                end else begin
                    busy_d = busy_q - BC_W'(1);
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= '0;
            rx_stb   <= 1'b0;
            rx_count <= '0;
        end else begin
            rx_stb <= xfer;
            if (xfer) begin
                rx_data  <= crp.data;
                rx_count <= rx_count + CNT_W'(1);
            end
        end
    end

`ifdef VR_CONSUMER_CHECK_EN
    vr_seq_check #(
        .EXP_INIT (EXP_INIT),
        .CNT_W    (CNT_W)
    ) u_seq_check (
        .clk       (clk),
        .rst       (rst),
        .xfer      (xfer),
        .data      (crp.data),
        .err       (err),
        .err_count (err_count)
    );
`else
    assign err       = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vr_consumer.sv
// tb/tb_vr_consumer.sv - self-checking bench for vr_consumer (tracks VR_CONSUMER_CHECK_EN)
module tb_vr_consumer;
    import vr_pkg::*;

`ifdef VR_CONSUMER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, stall_a, stall_b;
    logic [7:0]  rx_data_a, rx_data_b;
    logic        rx_stb_a, rx_stb_b, err_a, err_b;
    logic [15:0] rx_count_a, err_count_a;
    logic [3:0]  rx_count_b, err_count_b;

    vr_i a_if();
    vr_i b_if();

    vr_consumer #(.BUSY_CYCLES(3), .EXP_INIT(8'h01), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .crp(a_if), .stall(stall_a),
        .rx_data(rx_data_a), .rx_stb(rx_stb_a), .rx_count(rx_count_a),
        .err(err_a), .err_count(err_count_a)
    );

    vr_consumer #(.BUSY_CYCLES(0), .EXP_INIT(8'hFE), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .crp(b_if), .stall(stall_b),
        .rx_data(rx_data_b), .rx_stb(rx_stb_b), .rx_count(rx_count_b),
        .err(err_b), .err_count(err_count_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a count of blocked cycles left, not a state machine.
    typedef struct {
        int         busy_left;
        bit         up;
        logic [7:0] rx_data;
        bit         rx_stb;
        int         rx_count;
        bit         err;
        int         err_count;
        logic [7:0] expct;
    } mdl_t;

    mdl_t ma, mb;
    bit   xfer_a, xfer_b;

    function automatic mdl_t mdl_init(input logic [7:0] e);
        mdl_t m;
        m.busy_left = 0; m.up = 0; m.rx_data = 0; m.rx_stb = 0;
        m.rx_count = 0; m.err = 0; m.err_count = 0; m.expct = e;
        return m;
    endfunction

    function automatic bit mdl_rdy(input mdl_t m, input bit s);
        return m.up && (m.busy_left == 0) && !s;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit v, input logic [7:0] d,
                                      input bit s, input int busy, input int modv);
        mdl_t r = m;
        bit   x = v && mdl_rdy(m, s);
        r.rx_stb = x;
        if (x) begin
            r.rx_data  = d;
            r.rx_count = (m.rx_count + 1) % modv;
            if (d != m.expct) begin
                r.err = 1;
                if (m.err_count < modv - 1) r.err_count = m.err_count + 1;
            end
            r.expct = d + 8'd1;
            r.busy_left = busy;
        end else if (m.up && m.busy_left > 0) begin
            r.busy_left = m.busy_left - 1;
        end
        r.up = 1;
        return r;
    endfunction

    task automatic cmp_outputs();
        chk("a_rx_data",   rx_data_a,   ma.rx_data);
        chk("a_rx_stb",    rx_stb_a,    ma.rx_stb);
        chk("a_rx_count",  rx_count_a,  ma.rx_count);
        chk("a_err",       err_a,       CHK ? ma.err : 1'b0);
        chk("a_err_count", err_count_a, CHK ? ma.err_count : 0);
        chk("b_rx_data",   rx_data_b,   mb.rx_data);
        chk("b_rx_stb",    rx_stb_b,    mb.rx_stb);
        chk("b_rx_count",  rx_count_b,  mb.rx_count);
        chk("b_err",       err_b,       CHK ? mb.err : 1'b0);
        chk("b_err_count", err_count_b, CHK ? mb.err_count : 0);
    endtask

    // Called at edge+1 with inputs already set; returns at the next edge+1.
    task automatic cycle();
        #1;
        if (rst_a) begin
            chk("a_rdy", a_if.rdy, mdl_rdy(ma, stall_a));
            xfer_a = a_if.valid & a_if.rdy;
            ma = mdl_step(ma, a_if.valid, a_if.data, stall_a, 3, 1 << 16);
        end else begin
            chk("a_rdy_in_rst", a_if.rdy, 0);
            xfer_a = 0;
            ma = mdl_init(8'h01);
        end
        if (rst_b) begin
            chk("b_rdy", b_if.rdy, mdl_rdy(mb, stall_b));
            xfer_b = b_if.valid & b_if.rdy;
            mb = mdl_step(mb, b_if.valid, b_if.data, stall_b, 0, 16);
        end else begin
            chk("b_rdy_in_rst", b_if.rdy, 0);
            xfer_b = 0;
            mb = mdl_init(8'hFE);
        end
        @(posedge clk);
        #1;
        cmp_outputs();
    endtask

    task automatic send_a(input logic [7:0] d);
        bit done = 0;
        a_if.valid = 1'b1;
        a_if.data  = d;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            done = xfer_a;
        end
        a_if.valid = 1'b0;
        chk("a_send_timeout", done, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         cnt;
        bit         err;
        int         ecnt;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] wrap_words[4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h01, 1, 1'b0, 0};
        vecs[1] = '{8'h02, 2, 1'b0, 0};
        vecs[2] = '{8'h03, 3, 1'b0, 0};
        vecs[3] = '{8'h05, 4, 1'b1, 1};
        vecs[4] = '{8'h06, 5, 1'b1, 1};
        vecs[5] = '{8'h07, 6, 1'b1, 1};
        vecs[6] = '{8'h09, 7, 1'b1, 2};
        vecs[7] = '{8'h0A, 8, 1'b1, 2};
        wrap_words[0] = 8'hFE; wrap_words[1] = 8'hFF;
        wrap_words[2] = 8'h00; wrap_words[3] = 8'h01;

        rst_a = 0; rst_b = 0; stall_a = 0; stall_b = 0;
        a_if.valid = 0; a_if.data = 0; b_if.valid = 0; b_if.data = 0;
        ma = mdl_init(8'h01);
        mb = mdl_init(8'hFE);

        #2;
        chk("rst_rdy_a", a_if.rdy, 0);
        chk("rst_rx_count_a", rx_count_a, 0);
        chk("rst_rx_data_a", rx_data_a, 0);
        chk("rst_rx_stb_a", rx_stb_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_err_count_a", err_count_a, 0);
        @(posedge clk); #1;
        cycle();
        rst_a = 1; rst_b = 1;
        chk("first_cycle_rdy_low", a_if.rdy, 0);
        cycle();
        chk("second_cycle_rdy_high", a_if.rdy, 1);

        // Table: stream with one gap pair, BUSY_CYCLES=3 throttle after each accept.
        for (int i = 0; i < 8; i++) begin
            send_a(vecs[i].data);
            chk("tbl_rx_stb", rx_stb_a, 1);
            chk("tbl_rx_data", rx_data_a, vecs[i].data);
            chk("tbl_rx_count", rx_count_a, vecs[i].cnt);
            chk("tbl_err", err_a, CHK ? vecs[i].err : 1'b0);
            chk("tbl_err_count", err_count_a, CHK ? vecs[i].ecnt : 0);
            for (int k = 0; k < 3; k++) begin
                chk("tbl_busy_rdy_low", a_if.rdy, 0);
                cycle();
            end
            chk("tbl_busy_done_rdy", a_if.rdy, 1);
        end

        // Stall for 10 cycles with a word waiting.
        stall_a = 1; a_if.valid = 1; a_if.data = 8'h0B;
        #1;
        chk("stall_drops_rdy", a_if.rdy, 0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("stall_no_accept", rx_count_a, 8);
        end
        stall_a = 0;
        #1;
        chk("unstall_rdy_comb", a_if.rdy, 1);
        cycle();
        a_if.valid = 0;
        chk("unstall_accept_stb", rx_stb_a, 1);
        chk("unstall_accept_cnt", rx_count_a, 9);
        chk("unstall_accept_data", rx_data_a, 8'h0B);

        // Asynchronous reset while a word is presented in C_RDY.
        repeat (3) cycle();
        a_if.valid = 1; a_if.data = 8'h0C;
        #2;
        rst_a = 0;
        #1;
        chk("async_rst_rdy", a_if.rdy, 0);
        chk("async_rst_cnt", rx_count_a, 0);
        chk("async_rst_data", rx_data_a, 0);
        chk("async_rst_err", err_a, 0);
        chk("async_rst_ecnt", err_count_a, 0);
        cycle();
        chk("rst_word_not_counted", rx_count_a, 0);
        rst_a = 1;
        chk("rel_rdy_low", a_if.rdy, 0);
        cycle();
        chk("rel_rdy_second", a_if.rdy, 1);
        cycle();
        a_if.valid = 0;
        chk("rel_first_accept", rx_count_a, 1);

        // Back-to-back accepts across the FF->00 wrap on the zero-busy instance.
        for (int i = 0; i < 4; i++) begin
            b_if.valid = 1; b_if.data = wrap_words[i];
            cycle();
            chk("b2b_stb", rx_stb_b, 1);
            chk("b2b_data", rx_data_b, wrap_words[i]);
            chk("b2b_no_err", err_b, 0);
        end
        b_if.valid = 0;
        chk("b2b_count", rx_count_b, 4);
        cycle();
        chk("b2b_stb_drop", rx_stb_b, 0);

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            a_if.valid = ($urandom_range(0, 3) != 0);
            a_if.data  = ($urandom_range(0, 3) != 0) ? ma.expct : 8'($urandom);
            stall_a    = ($urandom_range(0, 4) == 0);
            rst_a      = ($urandom_range(0, 299) != 0);
            b_if.valid = ($urandom_range(0, 3) != 0);
            b_if.data  = ($urandom_range(0, 2) != 0) ? mb.expct : 8'($urandom);
            stall_b    = ($urandom_range(0, 4) == 0);
            rst_b      = ($urandom_range(0, 999) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
